// File: rtl/k_rptr_empty_sync_pkg.sv
// -----------------------------------------------------------------------------
// k_rptr_empty_sync_pkg
// Shared definitions for the dual-clock FIFO pointer logic (read and write
// sides).
//   K_PTR_W : default pointer width, including the wrap bit.
//   K_FN_W  : working width of the gray/binary helper functions.
//   b2g()   : binary -> gray.
//   g2b()   : gray -> binary.
// The helpers work at K_FN_W bits. Callers zero-extend their operand to
// K_FN_W with a size cast and cast the result back to their own width. For a
// zero-extended operand, both conversions leave the upper bits at zero. The
// low bits therefore equal the conversion done at the caller's width, so one
// function pair serves every pointer width up to K_FN_W.
// -----------------------------------------------------------------------------
package k_rptr_empty_sync_pkg;

    localparam int K_PTR_W = 4;
    localparam int K_FN_W  = 32;

    // Binary to gray: each gray bit is the xor of two adjacent binary bits.
    function automatic logic [K_FN_W-1:0] b2g(input logic [K_FN_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary: each binary bit is the xor of all gray bits at or above
    // it. The loop builds that prefix xor in log2(K_FN_W) doubling steps.
    function automatic logic [K_FN_W-1:0] g2b(input logic [K_FN_W-1:0] gray);
        logic [K_FN_W-1:0] bin;
        bin = gray;
        for (int sh = 32'sd1; sh < K_FN_W; sh = sh * 32'sd2) begin
            bin = bin ^ (bin >> sh);
        end
        return bin;
    endfunction

endpackage

// File: rtl/k_rptr_empty_sync_sync.sv
// -----------------------------------------------------------------------------
// k_sync_ff
// Multi-stage flop chain that brings a gray-coded pointer into a new clock
// domain. The flops have nothing between them. Every stage clears on the
// asynchronous active-low reset.
// Parameters:
//   WIDTH  : bus width.
//   STAGES : number of flops in the chain (2..4 in use).
// Ports:
//   clk   : destination-domain clock.
//   rst_n : asynchronous active-low reset.
//   d_i   : unsynchronized input bus.
//   q_o   : output of the last stage.
// -----------------------------------------------------------------------------
module k_sync_ff #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift register: stage 0 samples the foreign bus and each later stage copies its predecessor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/k_rptr_empty_sync.sv
// -----------------------------------------------------------------------------
// k_rptr_empty_sync
// Read-side pointer and empty-flag generator for the dual-clock FIFO.
//
// The module syncs the write-domain gray pointer into the read clock. It keeps
// a binary read counter and a registered gray copy of that counter. It
// produces a registered, pessimistic empty flag.
//
// Parameters:
//   data_size   : pointer width including the wrap bit. The RAM depth is
//                 2^(data_size-1). The helper functions limit data_size to 32.
//   sync_stages : synchronizer depth for wptr_async (2..4).
// Ports:
//   clk        : read-domain clock.
//   rst_n      : asynchronous active-low reset.
//   inc        : read request. It pops one entry when empty is low.
//   wptr_async : gray write pointer from the write domain, unsynchronized.
//   rptr       : registered gray read pointer, sent to the write domain.
//   raddr      : RAM read address (low bits of the binary read pointer).
//   empty      : registered empty flag.
//   rd_ok      : inc && !empty. It is high in the cycle a pop is accepted.
//   rlevel     : (only with K_RD_LEVEL_EN) registered occupancy seen from the
//                read side.
// Optional feature:
//   K_RD_LEVEL_EN : when defined, adds the rlevel output and its
//                   gray-to-binary conversion of the synced write pointer.
// -----------------------------------------------------------------------------
module k_rptr_empty_sync
    import k_rptr_empty_sync_pkg::*;
#(
    parameter int data_size   = K_PTR_W,
    parameter int sync_stages = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic [data_size-1:0] wptr_async,
    output logic [data_size-1:0] rptr,
    output logic [data_size-2:0] raddr,
    output logic                 empty,
    output logic                 rd_ok
`ifdef K_RD_LEVEL_EN
    ,
    output logic [data_size-1:0] rlevel
`endif
);

    logic [data_size-1:0] wsync_s;
    logic                 rd_ok_s;
    logic [data_size-1:0] rbin_q;
    logic [data_size-1:0] rbin_d;
    logic [data_size-1:0] rptr_q;
    logic [data_size-1:0] rptr_d;
    logic                 empty_q;
    logic                 empty_d;

    // Write pointer crosses into the read domain through a plain flop chain.
    k_sync_ff #(
        .WIDTH  (data_size),
        .STAGES (sync_stages)
    ) u_wptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (wptr_async),
        .q_o   (wsync_s)
    );

    // A request made while empty is dropped here, so the counter cannot underflow.
    assign rd_ok_s = inc && !empty_q;

    // Next read pointer in binary and gray, and the empty flag it implies.
    always_comb begin
        rbin_d  = rbin_q + {{(data_size-1){1'b0}}, rd_ok_s};
        rptr_d  = data_size'(b2g(K_FN_W'(rbin_d)));
        // The comparison uses the post-pop pointer. A pop that takes the last
        // entry therefore raises empty on the same edge. A write the
        // synchronizer has not delivered yet keeps empty high, so empty is
        // never cleared early.
        empty_d = (rptr_d == wsync_s);
    end

    // Read pointer state and empty flag update together on each read clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbin_q  <= {data_size{1'b0}};
            rptr_q  <= {data_size{1'b0}};
            empty_q <= 1'b1;
        end else begin
            rbin_q  <= rbin_d;
            rptr_q  <= rptr_d;
            empty_q <= empty_d;
        end
    end

`ifdef K_RD_LEVEL_EN
    logic [data_size-1:0] rlevel_q;
    logic [data_size-1:0] rlevel_d;

    // Occupancy = synced write count minus post-pop read count (wraps naturally).
    always_comb begin
        rlevel_d = data_size'(g2b(K_FN_W'(wsync_s))) - rbin_d;
    end

    // Occupancy register; it changes on the same edge as the empty flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rlevel_q <= {data_size{1'b0}};
        end else begin
            rlevel_q <= rlevel_d;
        end
    end

    assign rlevel = rlevel_q;
`endif

    assign rptr  = rptr_q;
    assign raddr = rbin_q[data_size-2:0];
    assign empty = empty_q;
    assign rd_ok = rd_ok_s;

endmodule
